// File: rtl/instruction_fetch_unit.sv
// Sequential fetch stage: PC -> MAR -> memory -> MDR -> IR.
// Drives the ir bus and reports fetch completion or timeout.
module instruction_fetch_unit #(
   parameter int          ADDR_WIDTH = 9,
   parameter int unsigned PC_RESET   = 0,
   parameter int          TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  fetch_req,
   input  logic                  pc_load,
   input  logic [ADDR_WIDTH-1:0] pc_in,
   input  logic [31:0]           mem_data,
   input  logic                  mem_ready,
   output logic                  mem_read,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           ir,
   output logic [ADDR_WIDTH-1:0] pc,
   output logic                  busy,
   output logic                  fetch_done,
   output logic                  fetch_err
);

   localparam int CW = $clog2(TIMEOUT) + 1;
   localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      T0   = 2'd1,
      T1   = 2'd2,
      T2   = 2'd3
   } state_t;

   state_t                  state_q;
   state_t                  state_d;
   logic [ADDR_WIDTH-1:0]   mar;
   logic [31:0]             mdr;
   logic [CW-1:0]           wait_cnt;

   logic done_d;
   logic err_d;
   logic ld_mar;
   logic ld_mdr;
   logic ld_ir;
   logic inc_pc;
   logic cnt_clr;
   logic cnt_inc;

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      err_d   = 1'b0;
      ld_mar  = 1'b0;
      ld_mdr  = 1'b0;
      ld_ir   = 1'b0;
      inc_pc  = 1'b0;
      cnt_clr = 1'b0;
      cnt_inc = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (fetch_req) state_d = T0;
         end
         T0: begin
            ld_mar  = 1'b1;
            inc_pc  = 1'b1;
            cnt_clr = 1'b1;
            state_d = T1;
         end
         T1: begin
            if (mem_ready) begin
               ld_mdr  = 1'b1;
               state_d = T2;
            end else if (wait_cnt == WAIT_LAST) begin
               err_d   = 1'b1;
               state_d = IDLE;
            end else begin
               cnt_inc = 1'b1;
            end
         end
         T2: begin
            ld_ir   = 1'b1;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // pc_load outranks the T0 increment; MAR still sees the old pc in T0
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q    <= IDLE;
         pc         <= ADDR_WIDTH'(PC_RESET);
         mar        <= '0;
         mdr        <= '0;
         ir         <= '0;
         wait_cnt   <= '0;
         fetch_done <= 1'b0;
         fetch_err  <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_done <= done_d;
         fetch_err  <= err_d;
         if (pc_load)     pc <= pc_in;
         else if (inc_pc) pc <= pc + ADDR_WIDTH'(1);
         if (ld_mar) mar <= pc;
         if (ld_mdr) mdr <= mem_data;
         if (ld_ir)  ir  <= mdr;
         if (cnt_clr)      wait_cnt <= '0;
         else if (cnt_inc) wait_cnt <= wait_cnt + CW'(1);
      end
   end

   assign mem_read = (state_q == T1);
   assign busy     = (state_q != IDLE);
   assign mem_addr = mar;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit against a
// transaction-level model (address, latency, pc/ir outcome).
module tb_instruction_fetch_unit;

   localparam int AW = 9;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          clr;
   logic          fetch_req;
   logic          pc_load;
   logic [AW-1:0] pc_in;
   logic [31:0]   mem_data;
   logic          mem_ready;
   logic          mem_read;
   logic [AW-1:0] mem_addr;
   logic [31:0]   ir;
   logic [AW-1:0] pc;
   logic          busy;
   logic          fetch_done;
   logic          fetch_err;

   logic [31:0]   mem [512];
   logic [AW-1:0] m_pc;
   logic [31:0]   m_ir;
   int            n_vec = 0;
   int            n_bad = 0;

   instruction_fetch_unit #(
      .ADDR_WIDTH(AW),
      .PC_RESET  (0),
      .TIMEOUT   (TO)
   ) dut (
      .clk       (clk),
      .clr       (clr),
      .fetch_req (fetch_req),
      .pc_load   (pc_load),
      .pc_in     (pc_in),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .mem_read  (mem_read),
      .mem_addr  (mem_addr),
      .ir        (ir),
      .pc        (pc),
      .busy      (busy),
      .fetch_done(fetch_done),
      .fetch_err (fetch_err)
   );

   always #5 clk = ~clk;

   assign mem_data = mem[mem_addr];

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_pc(input logic [AW-1:0] t);
      pc_load = 1'b1;
      pc_in   = t;
      @(posedge clk);
      @(negedge clk);
      pc_load = 1'b0;
      m_pc    = t;
      chk("set_pc", 32'(pc), 32'(m_pc));
   endtask

   // delay: T1 cycles without mem_ready before it rises
   // mid_at: T1 cycle index at which pc_load(mid_tgt) fires, -1 none
   task automatic do_fetch(input int delay, input bit ld,
                           input logic [AW-1:0] tgt, input int mid_at,
                           input logic [AW-1:0] mid_tgt);
      logic [AW-1:0] addr;
      int  edges;
      int  rd;
      int  last_rd;
      bit  done;
      bit  err;
      bit  ok;
      edges = 0;
      rd    = 0;
      done  = 1'b0;
      err   = 1'b0;
      addr  = ld ? tgt : m_pc;
      fetch_req = 1'b1;
      pc_load   = ld;
      pc_in     = tgt;
      while (edges < 40 && !done && !err) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
         fetch_req = 1'b0;
         pc_load   = 1'b0;
         mem_ready = 1'b0;
         if (fetch_done) done = 1'b1;
         if (fetch_err)  err  = 1'b1;
         if (!done && !err) chk("busy", 32'(busy), 32'd1);
         else chk("busy_idle", 32'(busy), 32'd0);
         if (mem_read) begin
            chk("mem_addr", 32'(mem_addr), 32'(addr));
            if (rd == delay) mem_ready = 1'b1;
            if (rd == mid_at) begin
               pc_load = 1'b1;
               pc_in   = mid_tgt;
            end
            rd++;
         end
      end
      ok      = (delay < TO);
      last_rd = ok ? delay : TO - 1;
      chk("done", 32'(done), 32'(ok));
      chk("err", 32'(err), 32'(!ok));
      chk("latency", 32'(edges - 1), ok ? 32'(delay + 3) : 32'(TO + 1));
      chk("rd_cycles", 32'(rd), ok ? 32'(delay + 1) : 32'(TO));
      if (ok) m_ir = mem[addr];
      if (mid_at >= 0 && mid_at <= last_rd) m_pc = mid_tgt;
      else m_pc = AW'(addr + 1);
      chk("pc", 32'(pc), 32'(m_pc));
      chk("ir", ir, m_ir);
   endtask

   initial begin
      int dly;
      int mid;
      bit ld;
      clr       = 1'b1;
      fetch_req = 1'b0;
      pc_load   = 1'b0;
      pc_in     = '0;
      mem_ready = 1'b0;
      for (int i = 0; i < 512; i++) mem[i] = $urandom;
      mem[5] = 32'h1A8C_0000;

      @(posedge clk);
      @(negedge clk);
      clr  = 1'b0;
      m_pc = '0;
      m_ir = '0;
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_ir", ir, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_mem_read", 32'(mem_read), 32'd0);
      chk("rst_done", 32'(fetch_done), 32'd0);
      chk("rst_err", 32'(fetch_err), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);

      set_pc(9'd5);
      do_fetch(0, 1'b0, '0, -1, '0);
      chk("single_ir", ir, 32'h1A8C_0000);
      do_fetch(3, 1'b0, '0, -1, '0);
      do_fetch(100, 1'b0, '0, -1, '0);
      do_fetch(15, 1'b0, '0, -1, '0);
      do_fetch(16, 1'b0, '0, -1, '0);
      do_fetch(0, 1'b1, 9'd511, -1, '0);
      chk("wrap_pc", 32'(pc), 32'd0);
      do_fetch(2, 1'b1, 9'd511, 1, 9'd40);
      chk("midload_pc", 32'(pc), 32'd40);

      // clr in the second T1 cycle
      fetch_req = 1'b1;
      @(posedge clk);
      @(negedge clk);
      fetch_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("t1_first", 32'(mem_read), 32'd1);
      @(posedge clk);
      @(negedge clk);
      chk("t1_second", 32'(mem_read), 32'd1);
      clr     = 1'b1;
      pc_load = 1'b1;
      pc_in   = 9'd77;
      @(posedge clk);
      @(negedge clk);
      clr     = 1'b0;
      pc_load = 1'b0;
      m_pc    = '0;
      m_ir    = '0;
      chk("clr_mem_read", 32'(mem_read), 32'd0);
      chk("clr_busy", 32'(busy), 32'd0);
      chk("clr_ir", ir, 32'd0);
      chk("clr_pc", 32'(pc), 32'd0);
      chk("clr_done", 32'(fetch_done), 32'd0);
      chk("clr_err", 32'(fetch_err), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("clr_done2", 32'(fetch_done), 32'd0);
      chk("clr_err2", 32'(fetch_err), 32'd0);
      do_fetch(1, 1'b0, '0, -1, '0);

      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 7) == 0) dly = TO + $urandom_range(0, 4);
         else dly = $urandom_range(0, 6);
         ld  = ($urandom_range(0, 3) == 0);
         mid = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : -1;
         do_fetch(dly, ld, AW'($urandom), mid, AW'($urandom));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Sequential fetch stage that reads the next instruction word from memory into the instruction register. It drives the `ir` bus consumed by the register select/encode logic: Gra/Grb/Grc field decode and Rin/Rout/BAout one-hot generation. It owns the PC, MAR and MDR fetch path, handshakes with the memory subsystem, and tells the control unit when a new instruction is valid.

## Interface
- `ADDR_WIDTH`, default 9: PC/MAR width, giving a 512-word memory.
- `PC_RESET`, default 0: PC value after `clr`.
- `TIMEOUT`, default 16: maximum number of T1 cycles spent waiting for `mem_ready` before aborting.
- `clk`, in, 1: the only clock. All state changes on its rising edge.
- `clr`, in, 1: synchronous, active-high reset.
- `fetch_req`, in, 1: control unit requests a fetch. Sampled only in IDLE.
- `pc_load`, in, 1: load `pc_in` into PC.
- `pc_in`, in, ADDR_WIDTH: branch/jump target.
- `mem_data`, in, 32: memory read data.
- `mem_ready`, in, 1: `mem_data` is valid this cycle.
- `mem_read`, out, 1: read strobe to memory.
- `mem_addr`, out, ADDR_WIDTH: equals MAR.
- `ir`, out, 32: instruction register, feeding the select/encode stage.
- `pc`, out, ADDR_WIDTH: current PC.
- `busy`, out, 1: high whenever state is not IDLE.
- `fetch_done`, out, 1: one-cycle pulse; `ir` holds the new instruction.
- `fetch_err`, out, 1: one-cycle pulse; fetch aborted on timeout.

## Operation
- States: IDLE, T0, T1, T2. Registers: `pc`, `mar`, `mdr` (32-bit), `ir`, `wait_cnt` (clog2(TIMEOUT)+1 bits), plus the `fetch_done` and `fetch_err` flags.
- **IDLE**
  - `fetch_req`=1 → T0.
  - `fetch_req` is ignored in any other state; no queuing.
- **T0**
  - `mar` <= `pc`.
  - `pc` <= `pc`+1, modulo 2^ADDR_WIDTH; 511 wraps to 0.
  - `wait_cnt` <= 0.
  - → T1.
- **T1**
  - `mem_read`=1 (combinational, state==T1).
  - `mem_ready`=1 → `mdr` <= `mem_data`, → T2.
  - Otherwise `wait_cnt`++.
  - When `wait_cnt` reaches TIMEOUT-1 without `mem_ready`: → IDLE, `fetch_err` pulse. `ir` and `mdr` are unchanged.
- **T2**
  - `ir` <= `mdr`.
  - `fetch_done` <= 1 for one cycle.
  - → IDLE.
- **`pc_load` priority and collisions**
  - `pc_load` is honoured in every state and has priority over the T0 increment (`pc` <= `pc_in`).
  - In T0, MAR still takes the old `pc`, so the in-flight fetch completes from the old address.
  - `pc_load` and `fetch_req` in the same IDLE cycle: the fetch uses `pc_in`, because T0 reads the updated PC.
- `ir` changes only in T2 or on `clr`. `ir` is never partially updated.

## Timing
- Reset values after a `clr` edge:
  - state IDLE
  - `pc`=PC_RESET
  - `mar`=0, `mdr`=0, `ir`=0
  - `wait_cnt`=0
  - `mem_read`=0, `busy`=0, `fetch_done`=0, `fetch_err`=0
- `clr` overrides everything, including `pc_load`, in any state.
- `clr` in mid-fetch aborts silently, with no `fetch_err`. `mem_read` is low in the cycle after the `clr` edge.
- Edge numbering: `fetch_req` sampled at edge E0. E1 is the T0 update, so T1 starts in the cycle after E1.
- Minimum latency (`mem_ready` high in the first T1 cycle):
  - `mdr` is captured at E2.
  - `ir` is updated at E3.
  - `fetch_done` is high in the cycle after E3.
  - Request to new `ir` is 3 edges.
- Each wait cycle without `mem_ready` adds 1 cycle.
- Back-to-back fetches: state is IDLE during the `fetch_done` cycle, so `fetch_req` sampled at the end of that cycle starts the next fetch.
- `busy` is high from the cycle after E0 through the T2 cycle, inclusive.
- Timeout: T1 lasts exactly TIMEOUT cycles. `fetch_err` is high the cycle after leaving T1. `pc` keeps its incremented value.
- `mem_addr` is stable throughout T1.

## Test plan
- **Reset:** assert `clr` for 1 cycle → `pc`=0, `ir`=0, `busy`=0, `mem_read`=0, and no pulses.
- **Single fetch:** `pc`=5, memory[5]=0x1A8C_0000, `mem_ready` held high, `fetch_req` for 1 cycle →
  - `mem_addr`=5 during T1;
  - `ir`=0x1A8C_0000 3 edges after the request;
  - `fetch_done` pulses once;
  - `pc`=6.
- **Wait states:** `mem_ready` delayed 3 T1 cycles → `ir` is valid 6 edges after the request, with `mem_read` high for 4 cycles.
- **Timeout:** `mem_ready` never asserted → `mem_read` high for exactly 16 cycles, then a single `fetch_err` pulse; `ir` keeps its previous value and `pc` is incremented.
- **Load/wrap:**
  - `pc_load`=1 with `pc_in`=511 together with `fetch_req` → fetch from address 511, `pc` becomes 0.
  - `pc_load` with `pc_in`=40 during T1 → `pc`=40 and the current fetch is still from 511.
- **Reset mid-fetch:** `clr` in the second T1 cycle → IDLE next cycle, `mem_read`=0, `ir`=0, no `fetch_done` or `fetch_err`. A subsequent fetch from PC_RESET completes normally.
